data_output: RTL
================

// Module: data_output
// PURPOSE
//  FPGA->RPi direction of the serial data link. Buffers 16-bit words written by
//  fabric logic, serialises them LSB-first on the RPi-supplied bit clock, and
//  raises rpi_interrupt to request refill when the buffer runs low.
//  Single clk domain; rpi_clk is an asynchronous input sampled internally.
// PARAMETERS
//  DATA_W     16  word width, bits per serial frame
//  DEPTH      64  FIFO depth in words (power of two)
//  ADDR_W     6   log2(DEPTH)
//  IRQ_LEVEL  32  rpi_interrupt asserted while level < IRQ_LEVEL
// PORTS
//  clk            in   1        system clock, >= 8x rpi_clk frequency
//  rst_n          in   1        asynchronous active-low reset
//  wr_en          in   1        push wr_data this cycle
//  wr_data        in   DATA_W   word to transmit
//  full           out  1        FIFO holds DEPTH words
//  level          out  ADDR_W+1 words in FIFO (0..DEPTH)
//  overflow       out  1        sticky: push dropped while full
//  underrun       out  1        sticky: word boundary reached with FIFO empty
//  enable         in   1        transmit enable
//  rpi_clk        in   1        RPi bit clock (async)
//  serial         out  1        serial data to RPi
//  rpi_interrupt  out  1        refill request to RPi
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, shift reg 0, bit_cnt 0, state IDLE.
//  rpi_clk: 2-flop synchroniser + edge flop; rise_tick / fall_tick = 1-clk pulses.
//  serial changes only on fall_tick; RPi samples on rpi_clk rising edge.
//  FSM (state, bit_cnt[3:0], shreg[DATA_W-1:0]):
//   IDLE : serial=0, bit_cnt=0. On fall_tick with enable=1 -> LOAD.
//   LOAD : same clk: if FIFO non-empty pop head to shreg, else shreg=0 and set
//          underrun. serial<=shreg_next[0], bit_cnt<=1 -> SHIFT.
//   SHIFT: each fall_tick: if bit_cnt!=0 serial<=shreg[bit_cnt], bit_cnt++;
//          when bit_cnt wraps 15->0 the frame is done: if enable=1 the same
//          fall_tick performs LOAD of next word (back-to-back, no gap bit),
//          else -> IDLE, serial=0.
//  enable deassert mid-frame: current frame completes all 16 bits, then IDLE.
//  Pop occurs exactly at frame start; word is removed from FIFO on that clk.
//  FIFO: write accepted when !full, or when full and a pop occurs same clk.
//   Dropped write sets overflow. Push+pop same clk: level unchanged.
//   Pointers ADDR_W bits, wrap modulo DEPTH; level = wr_cnt - rd_cnt (ADDR_W+1).
//  full = (level==DEPTH); registered with FIFO state, valid same clk as level.
//  rpi_interrupt registered: 1 when enable=1 and level<IRQ_LEVEL, else 0.
//  Sticky flags clear only on reset.
//  Reset mid-frame: serial returns to 0 immediately, frame abandoned, FIFO flushed.
// STRUCTURE
//  data_io_pkg: DATA_W, DEPTH, ADDR_W, IRQ_LEVEL defaults; tx_state_t
//   {IDLE, LOAD, SHIFT} shared with data_input framing constants.
//  Sub-module sync_fifo (DATA_W x DEPTH, wr/rd/level/full/empty); FSM,
//   synchroniser and IRQ logic in data_output.
// TESTING
//  1 push 16'hA5C3, enable=1, 16 rpi_clk periods -> serial LSB-first
//    1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 sampled on rises; level 1->0.
//  2 push 0x0001,0x8000 back-to-back, 32 rpi_clk -> bits 1,0x15 then 0x15,1; no gap.
//  3 push 64 words, 65th push with no pop -> full=1, level=64, overflow=1,
//    65th word never transmitted; push during pop at full -> accepted, level=64.
//  4 level 31 with enable=1 -> rpi_interrupt=1; push to 32 -> 0 next clk.
//  5 enable=1, FIFO empty, 16 rpi_clk -> serial all 0, underrun=1.
//  6 drop enable at bit 5 -> bits 6..15 still sent, then IDLE; rst_n=0 mid-frame
//    -> serial=0, level=0, flags=0 asynchronously.

Source files
------------

// File: rtl/data_io_pkg.sv
// Shared constants and types for the FPGA<->RPi serial data link.
package data_io_pkg;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 6;
  localparam int IRQ_LEVEL = 32;

  // Framing constants, shared with the receive direction.
  localparam int FRAME_BITS = DATA_W;
  localparam int BIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  // True when the bit counter points at the final bit of a frame.
  function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
    return cnt == BIT_CNT_W'(FRAME_BITS - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with registered level/full/empty.
// A write while full is still accepted if a read happens in the same cycle.
module sync_fifo
  import data_io_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int DP = DEPTH,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          wr_drop
);

  logic [DW-1:0] mem_q [DP];
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_wr, do_rd;

  // Accept/drop decision, pointer advance and next-cycle status flags.
  always_comb begin
    do_rd    = rd_en & ~empty_q;
    do_wr    = wr_en & (~full_q | do_rd);
    wr_drop  = wr_en & ~do_wr;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (do_wr) wr_cnt_d = wr_cnt_q + 1'b1;
    if (do_rd) rd_cnt_d = rd_cnt_q + 1'b1;
    level_d = wr_cnt_d - rd_cnt_d;
    full_d  = (level_d == (AW+1)'(DP));
    empty_d = (level_d == '0);
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_cnt_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_cnt_q[AW-1:0]];
  assign level   = level_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/data_output.sv
// FPGA->RPi serial transmitter: FIFO-buffered words shifted out LSB-first,
// one bit per falling edge of the RPi bit clock, with a low-level refill IRQ.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | not transmitting, serial held low
//  LOAD  | 16 bits sent; next rpi_clk fall starts a new frame or idles
//  SHIFT | mid-frame, bit_cnt selects the next bit to drive
module data_output
  import data_io_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int DP  = DEPTH,
  parameter int AW  = ADDR_W,
  parameter int IRQ = IRQ_LEVEL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underrun,
  input  logic          enable,
  input  logic          rpi_clk,
  output logic          serial,
  output logic          rpi_interrupt
);

  localparam logic [AW:0] IRQ_LVL = (AW+1)'(IRQ);

  logic                 rpi_s1_q, rpi_s2_q, rpi_s3_q;
  logic                 fall_tick;
  tx_state_t            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]        shreg_q, shreg_d;
  logic                 serial_q, serial_d;
  logic                 overflow_q, overflow_d;
  logic                 underrun_q, underrun_d;
  logic                 irq_q, irq_d;
  logic                 do_load, pop;
  logic [DW-1:0]        fifo_rd_data;
  logic                 fifo_empty, fifo_drop;

  sync_fifo #(
    .DW (DW),
    .DP (DP),
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (level),
    .full    (full),
    .empty   (fifo_empty),
    .wr_drop (fifo_drop)
  );

  // Two-flop synchroniser plus edge-detect flop on the async bit clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpi_s1_q <= 1'b0;
      rpi_s2_q <= 1'b0;
      rpi_s3_q <= 1'b0;
    end else begin
      rpi_s1_q <= rpi_clk;
      rpi_s2_q <= rpi_s1_q;
      rpi_s3_q <= rpi_s2_q;
    end
  end

  assign fall_tick = rpi_s3_q & ~rpi_s2_q;

  // Frame sequencing; a frame start pops the FIFO head in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    serial_d   = serial_q;
    underrun_d = underrun_q;
    do_load    = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d  = 1'b0;
        bit_cnt_d = '0;
        if (fall_tick && enable) do_load = 1'b1;
      end
      LOAD: begin
        if (fall_tick) begin
          if (enable) begin
            do_load = 1'b1;
          end else begin
            state_d   = IDLE;
            serial_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          serial_d  = shreg_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (is_last_bit(bit_cnt_q)) state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_load) begin
      // An empty FIFO at a frame boundary sends an all-zero word.
      shreg_d    = fifo_empty ? '0 : fifo_rd_data;
      underrun_d = underrun_q | fifo_empty;
      serial_d   = shreg_d[0];
      bit_cnt_d  = BIT_CNT_W'(1);
      state_d    = SHIFT;
    end
  end

  assign pop = do_load & ~fifo_empty;

  // Sticky error flags and the refill request.
  always_comb begin
    overflow_d = overflow_q | fifo_drop;
    irq_d      = enable & (level < IRQ_LVL);
  end

  // Transmit state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      serial_q   <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      serial_q   <= serial_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      irq_q      <= irq_d;
    end
  end

  assign serial        = serial_q;
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;
  assign rpi_interrupt = irq_q;

endmodule
